// File: rtl/spi_pkg.sv
// Shared definitions for the debug-channel SPI receiver.
//   SPI_W          : bits per debug word
//   spi_rx_state_t : receiver frame state
//   *_IDLE         : level each SPI line rests at when no frame is active;
//                    the synchronizers reset to these so that reset itself
//                    never looks like line activity.
package spi_pkg;

    localparam int SPI_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_rx_state_t;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead synchronous word FIFO for the SPI receiver.
// The head word is held in a register so o_data is a flop output.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push         : request to store i_push_data
//   i_push_data    : word to store
//   i_pop          : consume head word (ignored while empty)
//   o_data         : head word (0 when empty)
//   o_valid        : FIFO not empty
//   o_level        : number of stored words
//   o_empty        : FIFO empty (decoded from level)
//   o_overflow     : one-cycle pulse when a push is dropped on a full FIFO
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int W     = SPI_W,
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [W-1:0]            i_push_data,
    input  logic                    i_pop,
    output logic [W-1:0]            o_data,
    output logic                    o_valid,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_empty,
    output logic                    o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [W-1:0]  r_head;
    logic          r_valid;
    logic          r_overflow;

    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_drop;
    logic [AW-1:0] w_rd_next;
    logic [LW-1:0] w_level_nxt;
    logic [W-1:0]  w_head_nxt;

    // Push/pop qualification; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        w_full    = (r_level == LW'(DEPTH));
        w_empty   = (r_level == {LW{1'b0}});
        w_do_pop  = i_pop & ~w_empty;
        w_do_push = i_push & (~w_full | w_do_pop);
        w_drop    = i_push & w_full & ~w_do_pop;
        w_rd_next = r_rd_ptr + AW'(1);
    end

    // Next fill level.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_do_push, w_do_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Next head word: with one word left and a simultaneous push, the
    // incoming word becomes the head directly since it is not in memory yet.
    always_comb begin
        w_head_nxt = r_head;
        if (w_do_pop) begin
            if (r_level > LW'(1)) begin
                w_head_nxt = r_mem[w_rd_next];
            end else if (w_do_push) begin
                w_head_nxt = i_push_data;
            end else begin
                w_head_nxt = {W{1'b0}};
            end
        end else if (w_empty && w_do_push) begin
            w_head_nxt = i_push_data;
        end else begin
            w_head_nxt = r_head;
        end
    end

    // Storage array.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, level and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_level    <= {LW{1'b0}};
            r_head     <= {W{1'b0}};
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_level    <= w_level_nxt;
            r_head     <= w_head_nxt;
            r_valid    <= (w_level_nxt != {LW{1'b0}});
            r_overflow <= w_drop;
        end
    end

    assign o_data     = r_head;
    assign o_valid    = r_valid;
    assign o_level    = r_level;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/spi_rx.sv
// Debug-side SPI receiver: oversamples sck/cs/mosi on i_clk, rebuilds
// MSB-first W-bit words and queues them in a show-ahead FIFO.
// Ports:
//   i_clk, i_rst_n : system clock (>= 4x SPI clock), async active-low reset
//   i_sck, i_cs, i_mosi : raw SPI lines (asynchronous, cs active-low)
//   o_out_data     : head-of-FIFO word, valid while o_out_valid
//   o_out_valid    : FIFO not empty
//   i_out_ready    : consumer accepts o_out_data
//   o_frame_err    : one-cycle pulse when a frame ends short
//   o_overflow     : one-cycle pulse when a complete word is dropped
//   o_level        : words held in the FIFO
module spi_rx
    import spi_pkg::*;
#(
    parameter int W     = SPI_W,
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_sck,
    input  logic                    i_cs,
    input  logic                    i_mosi,
    output logic [W-1:0]            o_out_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_frame_err,
    output logic                    o_overflow,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int CW = $clog2(W) + 1;

    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_cs_s1, r_cs_s2, r_cs_s3;
    logic r_mosi_s1, r_mosi_s2;

    logic r_sck_rise;
    logic r_cs_rise;
    logic r_cs_fall;
    logic r_post;
    logic r_armed;

    spi_rx_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [W-1:0]  r_shift, w_shift_nxt;
    logic          w_push;
    logic          w_err;
    logic          r_err_d;
    logic          r_frame_err;

    logic          w_pop;
    logic          w_empty;

    // Two-flop synchronizers plus a third sck/cs stage for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_s1  <= SCK_IDLE;
            r_sck_s2  <= SCK_IDLE;
            r_sck_s3  <= SCK_IDLE;
            r_cs_s1   <= CS_IDLE;
            r_cs_s2   <= CS_IDLE;
            r_cs_s3   <= CS_IDLE;
            r_mosi_s1 <= MOSI_IDLE;
            r_mosi_s2 <= MOSI_IDLE;
        end else begin
            r_sck_s1  <= i_sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_cs_s1   <= i_cs;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_mosi_s1 <= i_mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    // Registered edge strobes. r_armed only becomes set once cs has been
    // sampled high after reset, so a cs already low at reset release (which
    // the idle-reset synchronizer would otherwise present as a fall) is
    // ignored until the line goes high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_rise <= 1'b0;
            r_cs_rise  <= 1'b0;
            r_cs_fall  <= 1'b0;
            r_post     <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_sck_rise <= r_sck_s2 & ~r_sck_s3;
            r_cs_rise  <= r_cs_s2 & ~r_cs_s3;
            r_cs_fall  <= ~r_cs_s2 & r_cs_s3;
            r_post     <= 1'b1;
            r_armed    <= r_armed | (r_post & r_cs_s1);
        end
    end

    // Frame FSM next-state: cs rise takes priority over a same-cycle sck rise.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_cs_fall && r_armed) begin
                    w_state_nxt = SHIFT;
                    w_count_nxt = {CW{1'b0}};
                    w_shift_nxt = {W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (r_count == CW'(W)) begin
                    w_push      = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_cs_rise) begin
                    w_err       = (r_count != {CW{1'b0}});
                    w_state_nxt = IDLE;
                end else if (r_sck_rise) begin
                    w_shift_nxt = {r_shift[W-2:0], r_mosi_s2};
                    w_count_nxt = r_count + CW'(1);
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                if (r_cs_rise) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Frame FSM state, bit counter, shift register and error pulse pipeline.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_count     <= {CW{1'b0}};
            r_shift     <= {W{1'b0}};
            r_err_d     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_shift     <= w_shift_nxt;
            r_err_d     <= w_err;
            r_frame_err <= r_err_d;
        end
    end

    assign w_pop = i_out_ready & ~w_empty;

    spi_rx_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (w_pop),
        .o_data      (o_out_data),
        .o_valid     (o_out_valid),
        .o_level     (o_level),
        .o_empty     (w_empty),
        .o_overflow  (o_overflow)
    );

    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: a frame-level reference model fed from the
// pin levels seen at each clk edge predicts the FIFO contents and pulses;
// literal expectations pin the model on the directed scenarios.
module tb_spi_rx;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int HALF  = 4;   // sck half period in clk cycles
    localparam int LAT   = 4;   // pin sample to output effect

    logic clk = 1'b0;
    logic rst_n, sck, cs, mosi, ready;
    logic [W-1:0] out_data;
    logic out_valid, frame_err, overflow;
    logic [$clog2(DEPTH):0] level;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    spi_rx #(.W(W), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sck       (sck),
        .i_cs        (cs),
        .i_mosi      (mosi),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (ready),
        .o_frame_err (frame_err),
        .o_overflow  (overflow),
        .o_level     (level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic p_rst, p_sck, p_cs, p_mosi, p_ready;
    logic prv_sck, prv_cs;
    logic [31:0] q[$];
    bit          sch_push[8];
    bit          sch_err[8];
    logic [31:0] sch_word[8];
    int          mode;        // 0 no frame, 1 collecting, 2 word complete
    int          nb;
    logic [31:0] word;
    bit          armed;
    bit          e_valid, e_err, e_ovf;
    int          e_level;
    logic [31:0] e_data;

    task automatic model_step();
        int  s;
        int  t;
        bit  pop, push, drop;
        if (!p_rst) begin
            q.delete();
            for (int i = 0; i < 8; i++) begin
                sch_push[i] = 1'b0;
                sch_err[i]  = 1'b0;
            end
            mode = 0; nb = 0; word = 32'h0; armed = 1'b0;
            prv_sck = 1'b0; prv_cs = 1'b1;
            e_valid = 1'b0; e_err = 1'b0; e_ovf = 1'b0; e_level = 0; e_data = 32'h0;
            return;
        end
        s    = cyc % 8;
        t    = (cyc + LAT) % 8;
        pop  = e_valid && p_ready;
        push = sch_push[s];
        drop = push && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (push && !drop) q.push_back(sch_word[s]);
        e_ovf = drop;
        e_err = sch_err[s];
        sch_push[s] = 1'b0;
        sch_err[s]  = 1'b0;
        e_level = q.size();
        e_valid = (e_level > 0);
        e_data  = e_valid ? q[0] : 32'h0;
        // line events on this sample
        if (p_cs && !prv_cs) begin
            if (mode == 1 && nb > 0) sch_err[t] = 1'b1;
            mode = 0;
        end else if (!p_cs && prv_cs && armed) begin
            mode = 1; nb = 0; word = 32'h0;
        end else if (p_sck && !prv_sck && mode == 1) begin
            word = {word[30:0], p_mosi};
            nb++;
            if (nb == W) begin
                sch_push[t] = 1'b1;
                sch_word[t] = word;
                mode = 2;
            end
        end
        if (p_cs) armed = 1'b1;
        prv_sck = p_sck;
        prv_cs  = p_cs;
    endtask

    // ---------------- per-cycle observation ----------------
    logic        d_valid_q = 1'b0;
    logic [31:0] d_data_q  = 32'h0;
    logic [31:0] drained[$];
    int err_cnt = 0, ovf_cnt = 0, vcycles = 0;
    int rise_cyc = 0, vrise_cyc = 0, csr_cyc = 0, err_cyc = 0;

    initial begin : monitor
        forever begin
            @(posedge clk);
            cyc++;
            p_rst = rst_n; p_sck = sck; p_cs = cs; p_mosi = mosi; p_ready = ready;
            if (p_rst && d_valid_q && p_ready) drained.push_back(d_data_q);
            #1;
            model_step();
            chk("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
            chk("level", 32'(level), 32'(e_level));
            chk("frame_err", {31'h0, frame_err}, {31'h0, e_err});
            chk("overflow", {31'h0, overflow}, {31'h0, e_ovf});
            if (e_valid) chk("out_data", out_data, e_data);
            if (frame_err) begin err_cnt++; err_cyc = cyc; end
            if (overflow) ovf_cnt++;
            if (out_valid) begin
                vcycles++;
                if (!d_valid_q) vrise_cyc = cyc;
            end
            d_valid_q = out_valid;
            d_data_q  = out_data;
        end
    end

    function automatic logic [31:0] dget(input int i);
        if (i < drained.size()) return drained[i];
        return 32'hxxxxxxxx;
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b, input bit pop_here);
        mosi = b;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        rise_cyc = cyc + 1;
        for (int j = 1; j <= HALF; j++) begin
            @(negedge clk);
            if (pop_here && j == HALF) ready = 1'b1;
        end
        sck = 1'b0;
        if (pop_here) begin
            @(negedge clk);
            ready = 1'b0;
        end
    endtask

    task automatic cs_low_t();
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high_t();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        csr_cyc = cyc + 1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic frame(input logic [31:0] w, input int nbits, input bit pop_last);
        logic [31:0] v;
        v = w;
        cs_low_t();
        for (int i = 0; i < nbits; i++) send_bit(v[31-i], pop_last && (i == nbits - 1));
        cs_high_t();
    endtask

    initial begin : stim
        logic [31:0] rw;
        rst_n = 1'b0; sck = 1'b0; cs = 1'b1; mosi = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_ferr", {31'h0, frame_err}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single word, consumer always ready
        ready = 1'b1; drained.delete(); vcycles = 0;
        frame(32'hDEADBEEF, W, 1'b0);
        repeat (10) @(negedge clk);
        chk("t1_count", 32'(drained.size()), 32'd1);
        chk("t1_word", dget(0), 32'hDEADBEEF);
        chk("t1_valid_cycles", 32'(vcycles), 32'd1);
        chk("t1_latency", 32'(vrise_cyc - rise_cyc), 32'd4);
        chk("t1_level", 32'(level), 32'd0);

        // three back-to-back words held, then drained
        ready = 1'b0; drained.delete();
        frame(32'h00000001, W, 1'b0);
        frame(32'h80000000, W, 1'b0);
        frame(32'hFFFFFFFF, W, 1'b0);
        repeat (6) @(negedge clk);
        chk("t2_level", 32'(level), 32'd3);
        ready = 1'b1;
        repeat (8) @(negedge clk);
        ready = 1'b0;
        chk("t2_count", 32'(drained.size()), 32'd3);
        chk("t2_w0", dget(0), 32'h00000001);
        chk("t2_w1", dget(1), 32'h80000000);
        chk("t2_w2", dget(2), 32'hFFFFFFFF);

        // short frame then good frame
        err_cnt = 0; drained.delete();
        frame(32'hABCD0000, 17, 1'b0);
        repeat (8) @(negedge clk);
        chk("t3_err_pulses", 32'(err_cnt), 32'd1);
        chk("t3_err_latency", 32'(err_cyc - csr_cyc), 32'd4);
        chk("t3_level", 32'(level), 32'd0);
        ready = 1'b1;
        frame(32'h12345678, W, 1'b0);
        repeat (10) @(negedge clk);
        chk("t3_count", 32'(drained.size()), 32'd1);
        chk("t3_word", dget(0), 32'h12345678);
        chk("t3_err_after", 32'(err_cnt), 32'd1);

        // overflow on the fifth word
        ready = 1'b0; drained.delete(); ovf_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            rw = 32'hA0 + 32'(k);
            frame(rw, W, 1'b0);
        end
        chk("t4_level", 32'(level), 32'd4);
        chk("t4_ovf_pulses", 32'(ovf_cnt), 32'd1);

        // full FIFO, pop lands on the push cycle
        frame(32'h000000B5, W, 1'b1);
        chk("t5_level", 32'(level), 32'd4);
        chk("t5_ovf_pulses", 32'(ovf_cnt), 32'd1);
        ready = 1'b1;
        repeat (10) @(negedge clk);
        ready = 1'b0;
        chk("t5_count", 32'(drained.size()), 32'd5);
        chk("t5_w0", dget(0), 32'hA0);
        chk("t5_w1", dget(1), 32'hA1);
        chk("t5_w2", dget(2), 32'hA2);
        chk("t5_w3", dget(3), 32'hA3);
        chk("t5_w4", dget(4), 32'hB5);

        // reset mid-frame, released with cs still low
        err_cnt = 0; drained.delete(); ready = 1'b1;
        rw = 32'h5555AAAA;
        cs_low_t();
        for (int i = 0; i < 10; i++) send_bit(rw[31-i], 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 10; i < W; i++) send_bit(rw[31-i], 1'b0);
        cs_high_t();
        repeat (10) @(negedge clk);
        chk("t6_no_word", 32'(drained.size()), 32'd0);
        chk("t6_no_err", 32'(err_cnt), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        frame(32'hCAFEF00D, W, 1'b0);
        repeat (10) @(negedge clk);
        chk("t6_count", 32'(drained.size()), 32'd1);
        chk("t6_word", dget(0), 32'hCAFEF00D);
        chk("t6_err_after", 32'(err_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
